// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between port A (CPU,
// stalled through A_RDY) and port B (DMA / debug loader). One access per cycle,
// read data returned one cycle after the grant, and B starvation bounded by a
// streak limit on consecutive A grants while B waits.
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int MAX_STREAK = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DIN,
    output logic              A_RDY,
    output logic              A_VALID,
    output logic [DATA_W-1:0] A_DOUT,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_DIN,
    output logic              B_RDY,
    output logic              B_VALID,
    output logic [DATA_W-1:0] B_DOUT,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DIN,
    input  logic [DATA_W-1:0] MEM_DOUT
);

    localparam int STREAK_W = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_A,
        TAG_B
    } rd_tag_t;

    rd_tag_t             rd_tag;
    logic [STREAK_W-1:0] streak;
    logic [DATA_W-1:0]   a_hold;
    logic [DATA_W-1:0]   b_hold;
    logic                grant_a;
    logic                grant_b;

    // Grant decision: forced B once the A streak hits the limit, else A first.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (RST_N) begin
            if (B_REQ && (streak == STREAK_MAX)) begin
                grant_b = 1'b1;
            end else if (A_REQ) begin
                grant_a = 1'b1;
            end else if (B_REQ) begin
                grant_b = 1'b1;
            end
        end
    end

    assign A_RDY = grant_a;
    assign B_RDY = grant_b;

    // Memory command mux: the granted port drives the memory, idle drives zeros.
    always_comb begin
        MEM_WE   = 1'b0;
        MEM_ADDR = '0;
        MEM_DIN  = '0;
        if (grant_a) begin
            MEM_WE   = A_WE;
            MEM_ADDR = A_ADDR;
            MEM_DIN  = A_DIN;
        end else if (grant_b) begin
            MEM_WE   = B_WE;
            MEM_ADDR = B_ADDR;
            MEM_DIN  = B_DIN;
        end
    end

    // VALID is gated by reset so a read still in flight when reset asserts is
    // never reported; its rd_tag is cleared at that same edge.
    assign A_VALID = RST_N && (rd_tag == TAG_A);
    assign B_VALID = RST_N && (rd_tag == TAG_B);
    assign A_DOUT  = A_VALID ? MEM_DOUT : a_hold;
    assign B_DOUT  = B_VALID ? MEM_DOUT : b_hold;

    // Streak counter, read-owner tag and per-port read-data hold registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            streak <= '0;
            rd_tag <= TAG_NONE;
            a_hold <= '0;
            b_hold <= '0;
        end else begin
            if (grant_b || !B_REQ) begin
                streak <= '0;
            end else if (grant_a && (streak != STREAK_MAX)) begin
                streak <= streak + STREAK_W'(1);
            end

            if (grant_a && !A_WE) begin
                rd_tag <= TAG_A;
            end else if (grant_b && !B_WE) begin
                rd_tag <= TAG_B;
            end else begin
                rd_tag <= TAG_NONE;
            end

            if (A_VALID) begin
                a_hold <= MEM_DOUT;
            end
            if (B_VALID) begin
                b_hold <= MEM_DOUT;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives mem_arbiter with directed and random traffic against a
// behavioural memory, comparing every cycle with a reference model.
module tb_mem_arbiter;

    localparam int MAX = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        A_REQ, A_WE, A_RDY, A_VALID;
    logic [15:0] A_ADDR;
    logic [7:0]  A_DIN, A_DOUT;
    logic        B_REQ, B_WE, B_RDY, B_VALID;
    logic [15:0] B_ADDR;
    logic [7:0]  B_DIN, B_DOUT;
    logic        MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_DIN, MEM_DOUT;

    // Preload port of the behavioural memory (used only while in reset).
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic [7:0]  mem [0:65535];

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .ADDR_W(16),
        .DATA_W(8),
        .MAX_STREAK(MAX)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DIN(A_DIN),
        .A_RDY(A_RDY), .A_VALID(A_VALID), .A_DOUT(A_DOUT),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_DIN(B_DIN),
        .B_RDY(B_RDY), .B_VALID(B_VALID), .B_DOUT(B_DOUT),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
    );

    // Synchronous single-port memory: registered read, old data on a write cycle.
    always @(posedge CLK) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (MEM_WE) begin
            mem[MEM_ADDR] <= MEM_DIN;
        end
        MEM_DOUT <= mem[MEM_ADDR];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state (addresses kept within 0x000..0x1FF).
    logic [7:0] ref_mem [0:511];
    int         a_run;
    bit         pend_a, pend_b;
    logic [7:0] data_a, data_b, hold_a, hold_b;

    task automatic run_cycle(input bit rst, input bit ar, input bit aw, input logic [15:0] aa,
                             input logic [7:0] ad, input bit br, input bit bw,
                             input logic [15:0] ba, input logic [7:0] bd);
        int g;
        bit exp_va, exp_vb, exp_we;
        logic [15:0] exp_addr;
        logic [7:0] exp_din;
        @(posedge CLK);
        #1;
        RST_N = rst; A_REQ = ar; A_WE = aw; A_ADDR = aa; A_DIN = ad;
        B_REQ = br; B_WE = bw; B_ADDR = ba; B_DIN = bd;
        if (!rst) g = 0;
        else if (br && a_run == MAX) g = 2;
        else if (ar) g = 1;
        else if (br) g = 2;
        else g = 0;
        exp_we = 1'b0; exp_addr = 16'h0; exp_din = 8'h0;
        if (g == 1) begin exp_we = aw; exp_addr = aa; exp_din = ad; end
        if (g == 2) begin exp_we = bw; exp_addr = ba; exp_din = bd; end
        exp_va = rst && pend_a;
        exp_vb = rst && pend_b;
        #4;
        check("a_rdy", A_RDY, g == 1);
        check("b_rdy", B_RDY, g == 2);
        check("mem_we", MEM_WE, exp_we);
        check("mem_addr", MEM_ADDR, exp_addr);
        check("mem_din", MEM_DIN, exp_din);
        check("a_valid", A_VALID, exp_va);
        check("b_valid", B_VALID, exp_vb);
        check("a_dout", A_DOUT, exp_va ? data_a : hold_a);
        check("b_dout", B_DOUT, exp_vb ? data_b : hold_b);
        // Advance the model across the coming clock edge.
        if (!rst) begin
            a_run = 0; pend_a = 0; pend_b = 0; hold_a = 8'h0; hold_b = 8'h0;
        end else begin
            if (exp_va) hold_a = data_a;
            if (exp_vb) hold_b = data_b;
            pend_a = (g == 1) && !aw;
            pend_b = (g == 2) && !bw;
            if (pend_a) data_a = ref_mem[aa[8:0]];
            if (pend_b) data_b = ref_mem[ba[8:0]];
            if (g == 1 && aw) ref_mem[aa[8:0]] = ad;
            if (g == 2 && bw) ref_mem[ba[8:0]] = bd;
            if (g == 2 || !br) a_run = 0;
            else if (g == 1 && a_run < MAX) a_run++;
        end
    endtask

    task automatic idle(input bit rst);
        run_cycle(rst, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    endtask

    initial begin
        logic [9:0] grants;
        RST_N = 1'b0; A_REQ = 1'b0; A_WE = 1'b0; A_ADDR = '0; A_DIN = '0;
        B_REQ = 1'b0; B_WE = 1'b0; B_ADDR = '0; B_DIN = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        a_run = 0; pend_a = 0; pend_b = 0;
        data_a = '0; data_b = '0; hold_a = '0; hold_b = '0;

        // Preload the memory window while the arbiter is held in reset.
        for (int i = 0; i < 512; i++) begin
            @(posedge CLK);
            #1;
            ld_en = 1'b1;
            ld_addr = 16'(i);
            case (i)
                'h000:   ld_data = 8'hA2;
                'h107:   ld_data = 8'hAA;
                'h110:   ld_data = 8'hBB;
                'h1F7:   ld_data = 8'hCC;
                default: ld_data = 8'($urandom);
            endcase
            ref_mem[i] = ld_data;
        end
        @(posedge CLK);
        #1;
        ld_en = 1'b0;

        // Reset with both ports requesting.
        run_cycle(0, 1, 0, 16'h0000, 8'h0, 1, 0, 16'h0001, 8'h0);
        run_cycle(0, 1, 0, 16'h0000, 8'h0, 1, 0, 16'h0001, 8'h0);
        check("t1_a_dout", A_DOUT, 8'h00);
        check("t1_b_dout", B_DOUT, 8'h00);

        // Single A read of 0x0000.
        run_cycle(1, 1, 0, 16'h0000, 8'h0, 0, 0, 16'h0, 8'h0);
        check("t2_a_rdy", A_RDY, 1'b1);
        idle(1);
        check("t2_a_valid", A_VALID, 1'b1);
        check("t2_a_dout", A_DOUT, 8'hA2);

        // Both requesting: streak limit forces a B grant every fifth cycle.
        grants = '0;
        for (int i = 0; i < 10; i++) begin
            run_cycle(1, 1, 0, 16'($urandom_range(0, 511)), 8'h0,
                      1, 0, 16'($urandom_range(0, 511)), 8'h0);
            grants[i] = B_RDY;
        end
        check("t3_pattern", grants, 10'b10_0001_0000);
        idle(1);
        check("t3_b_valid", B_VALID, 1'b1);

        // B write followed by A read of the same address.
        run_cycle(1, 0, 0, 16'h0, 8'h0, 1, 1, 16'h0106, 8'h20);
        run_cycle(1, 1, 0, 16'h0106, 8'h0, 0, 0, 16'h0, 8'h0);
        check("t4_b_valid", B_VALID, 1'b0);
        idle(1);
        check("t4_a_valid", A_VALID, 1'b1);
        check("t4_a_dout", A_DOUT, 8'h20);

        // Reset right after an A read grant.
        run_cycle(1, 1, 0, 16'h0001, 8'h0, 0, 0, 16'h0, 8'h0);
        idle(0);
        check("t5_valid_rst", A_VALID, 1'b0);
        idle(1);
        check("t5_valid_after", A_VALID, 1'b0);
        check("t5_dout_after", A_DOUT, 8'h00);

        // Three back-to-back B reads.
        run_cycle(1, 0, 0, 16'h0, 8'h0, 1, 0, 16'h0107, 8'h0);
        run_cycle(1, 0, 0, 16'h0, 8'h0, 1, 0, 16'h0110, 8'h0);
        check("t6_dout0", B_DOUT, 8'hAA);
        run_cycle(1, 0, 0, 16'h0, 8'h0, 1, 0, 16'h01F7, 8'h0);
        check("t6_dout1", B_DOUT, 8'hBB);
        idle(1);
        check("t6_dout2", B_DOUT, 8'hCC);

        // Random traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            run_cycle($urandom_range(0, 63) != 0,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                      16'($urandom_range(0, 511)), 8'($urandom),
                      $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                      16'($urandom_range(0, 511)), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
